// File: rtl/puf_key_sampler.sv
// puf_key_sampler: drives a PUF generator through repeated arm/settle/sample
// rounds and majority-votes each response bit into a stable key. The key and
// its instability count are offered downstream on a valid/ready handshake.
//
// Handshake: key_valid_o is held high with key_o/unstable_count_o stable
// until a cycle where key_ready_i is also high. The transfer happens on that
// clock edge. key_valid_o and busy_o fall on the same edge. key_ready_i is
// don't-care while key_valid_o is low.
module puf_key_sampler #(
    parameter int WIDTH         = 1024,
    parameter int SAMPLES       = 7,
    parameter int SETTLE_CYCLES = 4,
    localparam int CW           = $clog2(SAMPLES + 1),
    localparam int UW           = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       challenge_i,
    output logic             busy_o,
    output logic             puf_enable_o,
    output logic [1:0]       puf_control_o,
    input  logic [WIDTH-1:0] puf_response_i,
    output logic [WIDTH-1:0] key_o,
    output logic             key_valid_o,
    input  logic             key_ready_i,
    output logic [UW-1:0]    unstable_count_o,
    output logic [2:0]       state_o
);

    localparam int STW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_VOTE   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       chal_q, chal_d;
    logic [CW-1:0]    sidx_q, sidx_d;
    logic [STW-1:0]   settle_q, settle_d;
    logic             busy_q, busy_d;
    logic             en_q, en_d;
    logic [1:0]       ctl_q, ctl_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] key_q;
    logic [UW-1:0]    unst_q;
    logic [CW-1:0]    cnt_q [WIDTH];

    logic             clear_cnt;
    logic             clear_res;
    logic             accum;
    logic             do_vote;
    logic [WIDTH-1:0] vote_key;
    logic [UW-1:0]    vote_unst;

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d   = state_q;
        chal_d    = chal_q;
        sidx_d    = sidx_q;
        settle_d  = settle_q;
        clear_cnt = 1'b0;
        clear_res = 1'b0;
        accum     = 1'b0;
        do_vote   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    chal_d    = challenge_i;
                    clear_cnt = 1'b1;
                    clear_res = 1'b1;
                    sidx_d    = '0;
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                settle_d = '0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == STW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + STW'(1);
                end
            end
            S_SAMPLE: begin
                accum  = 1'b1;
                sidx_d = sidx_q + CW'(1);
                if (sidx_q == CW'(SAMPLES - 1)) begin
                    state_d = S_VOTE;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_VOTE: begin
                do_vote = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (key_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        en_d    = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        ctl_d   = ((state_d == S_ARM) || (state_d == S_SETTLE) || (state_d == S_SAMPLE))
                  ? chal_d : 2'b00;
        valid_d = (state_d == S_DONE);
    end

    // Majority vote and instability count over the per-bit sample counters.
    always_comb begin
        vote_key  = '0;
        vote_unst = '0;
        for (int i = 0; i < WIDTH; i++) begin
            vote_key[i] = (cnt_q[i] > CW'(SAMPLES / 2));
            if ((cnt_q[i] != '0) && (cnt_q[i] != CW'(SAMPLES))) begin
                vote_unst = vote_unst + UW'(1);
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            chal_q   <= '0;
            sidx_q   <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            en_q     <= 1'b0;
            ctl_q    <= '0;
            valid_q  <= 1'b0;
            key_q    <= '0;
            unst_q   <= '0;
        end else begin
            state_q  <= state_d;
            chal_q   <= chal_d;
            sidx_q   <= sidx_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            en_q     <= en_d;
            ctl_q    <= ctl_d;
            valid_q  <= valid_d;
            if (clear_res) begin
                key_q  <= '0;
                unst_q <= '0;
            end else if (do_vote) begin
                key_q  <= vote_key;
                unst_q <= vote_unst;
            end
        end
    end

    // Per-bit ones counters, cleared at reset and at the start of each run.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (rst_i || clear_cnt) begin
                cnt_q[i] <= '0;
            end else if (accum) begin
                cnt_q[i] <= cnt_q[i] + CW'(puf_response_i[i]);
            end
        end
    end

    assign busy_o           = busy_q;
    assign puf_enable_o     = en_q;
    assign puf_control_o    = ctl_q;
    assign key_o            = key_q;
    assign key_valid_o      = valid_q;
    assign unstable_count_o = unst_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_puf_key_sampler.sv
// Bench for puf_key_sampler: timeline model of a key run compared every cycle,
// plus literal expectations for latency, keys and instability counts.
module tb_puf_key_sampler;

    localparam int W       = 1024;
    localparam int SAMPLES = 7;
    localparam int SETTLE  = 4;
    localparam int UW      = $clog2(W + 1);
    localparam int PERIOD  = SETTLE + 2;
    localparam int RUN     = SAMPLES * PERIOD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          start_i;
    logic [1:0]    challenge_i;
    logic          busy_o;
    logic          puf_enable_o;
    logic [1:0]    puf_control_o;
    logic [W-1:0]  puf_response_i;
    logic [W-1:0]  key_o;
    logic          key_valid_o;
    logic          key_ready_i;
    logic [UW-1:0] unstable_count_o;
    logic [2:0]    state_o;

    puf_key_sampler #(.WIDTH(W), .SAMPLES(SAMPLES), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .challenge_i     (challenge_i),
        .busy_o          (busy_o),
        .puf_enable_o    (puf_enable_o),
        .puf_control_o   (puf_control_o),
        .puf_response_i  (puf_response_i),
        .key_o           (key_o),
        .key_valid_o     (key_valid_o),
        .key_ready_i     (key_ready_i),
        .unstable_count_o(unstable_count_o),
        .state_o         (state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model ----------------
    // m_mode: 0 idle, 1 running (m_k = cycle index since start), 2 key offered
    int            m_mode = 0;
    int            m_k    = 0;
    logic [1:0]    m_chal = '0;
    logic [W-1:0]  m_key  = '0;
    logic [UW-1:0] m_unst = '0;
    logic [W-1:0]  samp_q [$];
    logic [W-1:0]  resp_tab [SAMPLES];
    logic          drive_tab = 1'b0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_mode = 0;
            m_key  = '0;
            m_unst = '0;
            samp_q.delete();
        end else begin
            case (m_mode)
                0: if (start_i) begin
                    m_mode = 1;
                    m_k    = 0;
                    m_chal = challenge_i;
                    m_key  = '0;
                    m_unst = '0;
                    samp_q.delete();
                end
                1: begin
                    if ((m_k < RUN) && (m_k % PERIOD == PERIOD - 1))
                        samp_q.push_back(puf_response_i);
                    if (m_k == RUN) begin
                        m_key  = '0;
                        m_unst = '0;
                        for (int b = 0; b < W; b++) begin
                            int ones;
                            ones = 0;
                            foreach (samp_q[s]) ones += int'(samp_q[s][b]);
                            m_key[b] = (ones > SAMPLES / 2);
                            if ((ones != 0) && (ones != SAMPLES)) m_unst = m_unst + 1'b1;
                        end
                        m_mode = 2;
                    end else begin
                        m_k++;
                    end
                end
                default: if (key_ready_i) m_mode = 0;
            endcase
        end
    end

    // Response driver: presents the table entry for the next sample to be taken.
    always @(negedge clk) begin
        if (drive_tab) begin
            puf_response_i = resp_tab[(samp_q.size() < SAMPLES) ? samp_q.size() : SAMPLES - 1];
        end else begin
            for (int j = 0; j < W / 32; j++) puf_response_i[j*32 +: 32] = $urandom;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_key(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: low64 got %0h, expected %0h (%0d bits differ)",
                     nm, cyc, act[63:0], exp[63:0], $countones(act ^ exp));
        end
    endtask

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("busy", busy_o, m_mode != 0);
        chk("puf_enable", puf_enable_o, (m_mode == 1) && (m_k < RUN) && (m_k % PERIOD != 0));
        chk("puf_control", puf_control_o, ((m_mode == 1) && (m_k < RUN)) ? m_chal : 2'b00);
        chk("key_valid", key_valid_o, m_mode == 2);
        chk("unstable_count", unstable_count_o, m_unst);
        chk_key("key", key_o, m_key);
    end

    // ---------------- driver tasks ----------------
    // Returns at the falling edge inside the first cycle after acceptance.
    task automatic run_start(input logic [1:0] chal);
        @(negedge clk);
        start_i     = 1'b1;
        challenge_i = chal;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int i;
        for (i = 0; i < 200; i++) begin
            if (key_valid_o) break;
            @(posedge clk);
            #1;
        end
        lat = key_valid_o ? (cyc - start_cyc) : -1;
    endtask

    task automatic accept_key();
        @(negedge clk);
        key_ready_i = 1'b1;
        @(negedge clk);
        key_ready_i = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    int            lat;
    int            vcount;
    logic [W-1:0]  pat;
    logic [W-1:0]  exp_key;
    logic [W-1:0]  held_key;
    logic [UW-1:0] held_unst;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; key_ready_i = 1'b0; challenge_i = 2'b00;

        // Reset with random inputs
        repeat (2) begin
            @(negedge clk);
            start_i     = 1'($urandom_range(0, 1));
            key_ready_i = 1'($urandom_range(0, 1));
            challenge_i = 2'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        chk("rst_state", state_o, 3'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_valid", key_valid_o, 1'b0);
        chk("rst_enable", puf_enable_o, 1'b0);
        chk("rst_control", puf_control_o, 2'b00);
        chk("rst_unstable", unstable_count_o, '0);
        chk_key("rst_key", key_o, '0);
        @(negedge clk);
        rst_i = 1'b0; start_i = 1'b0; key_ready_i = 1'b0; challenge_i = 2'b00;
        drive_tab = 1'b1;

        // Stable 0xA5 response
        pat = {128{8'hA5}};
        for (int j = 0; j < SAMPLES; j++) resp_tab[j] = pat;
        run_start(2'b10);
        wait_valid(lat);
        chk("stable_latency", lat, 43);
        chk_key("stable_key", key_o, pat);
        chk("stable_unstable", unstable_count_o, 0);
        accept_key();

        // Noisy bits: bit0 4/7, bit1 3/7, bit2 7/7
        for (int j = 0; j < SAMPLES; j++) begin
            resp_tab[j] = '0;
            resp_tab[j][0] = (j < 4);
            resp_tab[j][1] = (j < 3);
            resp_tab[j][2] = 1'b1;
        end
        run_start(2'b01);
        wait_valid(lat);
        chk("noisy_latency", lat, 43);
        exp_key = '0;
        exp_key[2:0] = 3'b101;
        chk_key("noisy_key", key_o, exp_key);
        chk("noisy_unstable", unstable_count_o, 2);
        accept_key();

        // Backpressure with a start pulse during DONE
        for (int j = 0; j < SAMPLES; j++) resp_tab[j] = {64{16'h1234}};
        run_start(2'b11);
        wait_valid(lat);
        held_key  = key_o;
        held_unst = unstable_count_o;
        chk_key("bp_key", held_key, {64{16'h1234}});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start_i     = (c == 5);
            challenge_i = 2'b00;
            @(posedge clk); #1;
            chk("bp_valid_hold", key_valid_o, 1'b1);
            chk("bp_unstable_hold", unstable_count_o, held_unst);
            chk_key("bp_key_hold", key_o, held_key);
        end
        @(negedge clk);
        key_ready_i = 1'b1;
        start_i     = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_fall", key_valid_o, 1'b0);
        chk("bp_busy_fall", busy_o, 1'b0);
        @(negedge clk);
        key_ready_i = 1'b0;
        start_i     = 1'b0;
        @(posedge clk); #1;
        chk("bp_no_rerun", busy_o, 1'b0);

        // Reset during the third SAMPLE, then a clean run
        for (int j = 0; j < SAMPLES; j++) resp_tab[j] = '1;
        run_start(2'b01);
        repeat (2 * PERIOD + PERIOD - 1) @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_enable", puf_enable_o, 1'b0);
        chk("midrst_control", puf_control_o, 2'b00);
        chk("midrst_state", state_o, 3'd0);
        @(negedge clk);
        rst_i = 1'b0;
        for (int j = 0; j < SAMPLES; j++) resp_tab[j] = (j % 2 == 0) ? {128{8'hFF}} : {128{8'h0F}};
        run_start(2'b10);
        wait_valid(lat);
        chk("midrst_latency", lat, 43);
        chk_key("midrst_key", key_o, {W{1'b1}});
        chk("midrst_unstable", unstable_count_o, 512);
        accept_key();

        // Start and challenge changes while busy are ignored
        for (int j = 0; j < SAMPLES; j++) resp_tab[j] = {128{8'h5A}};
        run_start(2'b11);
        @(negedge clk);
        @(negedge clk);
        start_i     = 1'b1;
        challenge_i = 2'b01;
        @(posedge clk); #1;
        chk("busy_start_control", puf_control_o, 2'b11);
        @(negedge clk);
        start_i = 1'b0;
        wait_valid(lat);
        chk("busy_start_latency", lat, 43);
        chk_key("busy_start_key", key_o, {128{8'h5A}});
        accept_key();
        vcount = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (key_valid_o) vcount++;
        end
        chk("busy_start_single_valid", vcount, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_key_sampler.md
# puf_key_sampler

Downstream consumer of the 1024-bit PUF generator. It drives the generator's `enable` and `control_input` and samples the raw response `SAMPLES` times, re-arming the oscillators between samples. A per-bit majority vote produces a stable key, together with a count of bits that flipped across samples. The key goes to the key-storage/ECC stage through a valid/ready handshake.

## Interface
- `WIDTH`, 1024: response/key width.
- `SAMPLES`, 7: number of response samples per key; must be odd, 3..15.
- `SETTLE_CYCLES`, 4: cycles `puf_enable` is held high before each sample; must be ≥1.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a key; accepted only in IDLE.
- `challenge` in 2: latched when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `puf_enable` out 1: drives generator `enable`.
- `puf_control` out 2: drives generator `control_input`.
- `puf_response` in WIDTH: generator output bits [WIDTH-1:0]; generator bit WIDTH is left unconnected.
- `key` out WIDTH: voted key.
- `key_valid` out 1: key available.
- `key_ready` in 1: downstream accepts the key.
- `unstable_count` out clog2(WIDTH+1) (11 at default): number of bits whose samples disagreed.

## Operation
- **States:** IDLE, ARM, SETTLE, SAMPLE, VOTE, DONE.
- **IDLE:**
  - All outputs are held low/zero, except that `key` and `unstable_count` retain the last result.
  - On `start`=1: latch `challenge`, clear all per-bit counters, clear `key` and `unstable_count`, set sample index to 0, go to ARM.
- **ARM (1 cycle):**
  - `puf_enable`=0, `puf_control`=latched challenge.
  - Go to SETTLE.
- **SETTLE (SETTLE_CYCLES cycles):**
  - `puf_enable`=1, `puf_control`=latched challenge.
  - Go to SAMPLE.
- **SAMPLE (1 cycle):**
  - `puf_enable`=1.
  - Each bit i: `cnt[i] += puf_response[i]`. Counters are clog2(SAMPLES+1) bits wide and cannot overflow.
  - Increment sample index. If index reaches SAMPLES, go to VOTE; otherwise go to ARM.
- **VOTE (1 cycle):**
  - `puf_enable`=0.
  - `key[i]` = (`cnt[i]` > SAMPLES/2, integer division).
  - `unstable_count` = number of i with 0 < `cnt[i]` < SAMPLES.
  - Go to DONE.
- **DONE:**
  - `key_valid`=1; `key` and `unstable_count` are held stable.
  - When `key_valid`&&`key_ready`, go to IDLE.
- `start` is ignored in every state except IDLE, including DONE and the handshake cycle itself.
- `challenge` changes while `busy` have no effect.
- `puf_control` is 0 in IDLE, VOTE and DONE.

## Timing
- **Reset** (any state, including mid-sample): next state IDLE. All outputs 0: `busy`, `puf_enable`, `puf_control`, `key`, `key_valid`, `unstable_count`. Counters and sample index are cleared.
- **Start-to-valid latency:** `start` is accepted at edge t. `key_valid` rises at edge t + SAMPLES×(SETTLE_CYCLES+2) + 1, which is t+43 at defaults.
- **Per-sample cadence:** 1 ARM + SETTLE_CYCLES SETTLE + 1 SAMPLE. `puf_response` is registered at the end of the SAMPLE cycle, i.e. after SETTLE_CYCLES+1 cycles of `puf_enable`=1.
- **Handshake:**
  - `key_valid` stays high until a cycle with `key_ready`=1.
  - It falls on the next edge, and `busy` falls on that same edge.
  - `key_ready` is ignored when `key_valid`=0.
- **Back-to-back:** the earliest next `start` acceptance is the cycle after the return to IDLE.
- All outputs are registered; no combinational input-to-output path.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs -> all outputs 0; state IDLE; `busy`=0.
- **Stable response:** `puf_response`=repeating 0xA5 pattern held constant; `challenge`=2'b10; `start` pulse -> `puf_control`=2'b10 whenever `puf_enable`=1; `puf_enable` low exactly 1 cycle between samples; `key_valid` at +43 cycles; `key`=pattern; `unstable_count`=0.
- **Noisy bits:** bit0 high in 4 of 7 samples, bit1 high in 3 of 7, bit2 high in 7 of 7, all others 0 -> `key`=...0101b (bit0=1, bit1=0, bit2=1); `unstable_count`=2.
- **Backpressure:** `key_ready`=0 for 10 cycles after `key_valid`, with `start` pulsed during DONE -> `key`/`key_valid`/`unstable_count` stable; no new run. `key_ready`=1 -> `key_valid`=0 and `busy`=0 next cycle.
- **Reset mid-operation:** assert `rst` during the 3rd SAMPLE -> all outputs 0 next cycle. A new `start` then runs a full 7 samples (43 cycles) with a correct key and no residue from the aborted counters.
- **Busy start/challenge:** during SETTLE, pulse `start` with `challenge`=2'b01 after the run started with 2'b11 -> `puf_control` stays 2'b11; only one `key_valid` results.
